// File: rtl/updi_pkg.sv
// Shared types and constants for the UPDI instruction issue engine.
package updi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNCH,
    ST_OPCODE,
    ST_DATA,
    ST_WAIT_ACK,
    ST_DONE
  } updi_state_t;

  typedef enum logic [1:0] {
    UPDI_ST_OK      = 2'b00,
    UPDI_ST_TIMEOUT = 2'b01,
    UPDI_ST_ABORT   = 2'b10
  } updi_status_t;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;

endpackage

// File: rtl/updi_timeout_counter.sv
// Cycle counter for ACK waits: expired is high in the LIMIT-th enabled cycle after clear.
module updi_timeout_counter #(
  parameter int WIDTH = 12,
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/updi_instr_issue_engine.sv
// Serialises one UPDI instruction (optional SYNCH, opcode, payload) into the TX FIFO,
// pausing for ACKs where requested, and reports success/timeout/abort.
module updi_instr_issue_engine
  import updi_pkg::*;
#(
  parameter int MAX_DATA_SIZE = 16,
  parameter int LEN_W         = $clog2(MAX_DATA_SIZE) + 1,
  parameter int ACK_TIMEOUT   = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic                       ready,
  output logic                       done,
  output logic [1:0]                 status,
  input  logic [7:0]                 opcode,
  input  logic [8*MAX_DATA_SIZE-1:0] data,
  input  logic [LEN_W-1:0]           data_len,
  input  logic [MAX_DATA_SIZE-1:0]   wait_ack_mask,
  input  logic                       send_synch,
  output logic                       waiting_for_ack,
  input  logic                       ack_received,
  output logic [7:0]                 fifo_data,
  output logic                       fifo_wr_en,
  input  logic                       fifo_full
);

  localparam int IDX_W = (MAX_DATA_SIZE > 1) ? $clog2(MAX_DATA_SIZE) : 1;
  localparam int TMR_W = $clog2(ACK_TIMEOUT);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA_SIZE);

  updi_state_t            state_reg;
  logic [7:0]             opcode_reg;
  logic [7:0]             data_reg [MAX_DATA_SIZE];
  logic [LEN_W-1:0]       len_reg;
  logic [LEN_W-1:0]       idx_reg;
  logic [MAX_DATA_SIZE-1:0] mask_reg;
  logic [1:0]             code_reg;
  logic [IDX_W-1:0]       idx_sel;
  logic                   last_byte;
  logic                   in_wait;
  logic                   ack_expired;
  logic                   accept;

  assign idx_sel         = idx_reg[IDX_W-1:0];
  assign last_byte       = (idx_reg == len_reg - LEN_W'(1));
  assign in_wait         = (state_reg == ST_WAIT_ACK);
  assign waiting_for_ack = in_wait;
  assign ready           = (state_reg == ST_IDLE) && !rst;
  assign accept          = (state_reg == ST_IDLE) && start;

  // The timer is held clear outside WAIT_ACK so every wait starts from zero.
  updi_timeout_counter #(
    .WIDTH (TMR_W),
    .LIMIT (ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (ack_expired)
  );

  // Payload bytes need no reset: they are only read after a capture.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < MAX_DATA_SIZE; i++) begin
        data_reg[i] <= data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= 8'h00;
      len_reg    <= '0;
      idx_reg    <= '0;
      mask_reg   <= '0;
      code_reg   <= UPDI_ST_OK;
      done       <= 1'b0;
      status     <= UPDI_ST_OK;
      fifo_wr_en <= 1'b0;
      fifo_data  <= 8'h00;
    end else begin
      fifo_wr_en <= 1'b0;
      done       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            opcode_reg <= opcode;
            len_reg    <= (data_len > MAX_LEN) ? MAX_LEN : data_len;
            mask_reg   <= wait_ack_mask;
            idx_reg    <= '0;
            state_reg  <= send_synch ? ST_SYNCH : ST_OPCODE;
          end
        end
        ST_SYNCH: begin
          if (abort) begin
            code_reg  <= UPDI_ST_ABORT;
            state_reg <= ST_DONE;
          end else if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= UPDI_SYNCH;
            state_reg  <= ST_OPCODE;
          end
        end
        ST_OPCODE: begin
          if (abort) begin
            code_reg  <= UPDI_ST_ABORT;
            state_reg <= ST_DONE;
          end else if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= opcode_reg;
            idx_reg    <= '0;
            if (len_reg == '0) begin
              code_reg  <= UPDI_ST_OK;
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (abort) begin
            code_reg  <= UPDI_ST_ABORT;
            state_reg <= ST_DONE;
          end else if (!fifo_full) begin
            fifo_wr_en <= 1'b1;
            fifo_data  <= data_reg[idx_sel];
            if (mask_reg[idx_sel]) begin
              state_reg <= ST_WAIT_ACK;
            end else if (last_byte) begin
              code_reg  <= UPDI_ST_OK;
              state_reg <= ST_DONE;
            end else begin
              idx_reg <= idx_reg + LEN_W'(1);
            end
          end
        end
        ST_WAIT_ACK: begin
          // Priority: abort, then ACK (even in the final timer cycle), then timeout.
          if (abort) begin
            code_reg  <= UPDI_ST_ABORT;
            state_reg <= ST_DONE;
          end else if (ack_received) begin
            if (last_byte) begin
              code_reg  <= UPDI_ST_OK;
              state_reg <= ST_DONE;
            end else begin
              idx_reg   <= idx_reg + LEN_W'(1);
              state_reg <= ST_DATA;
            end
          end else if (ack_expired) begin
            code_reg  <= UPDI_ST_TIMEOUT;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          status    <= code_reg;
          idx_reg   <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/updi_instr_issue_engine.md
UPDI_INSTR_ISSUE_ENGINE -- requirements
Module: updi_instr_issue_engine

Interface
REQ-001 SHALL have parameter MAX_DATA_SIZE, default 16, meaning maximum payload bytes per instruction.
REQ-002 SHALL have parameter LEN_W, default $clog2(MAX_DATA_SIZE)+1, meaning width of length fields.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 4096, meaning clk cycles allowed per ACK wait (>=2).
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset; reset rst, synchronous, active-high; clock clk.
REQ-005 SHALL have ports: start  in  1  launch request; abort  in  1  cancel in-flight instruction.
REQ-006 SHALL have ports: ready  out  1  idle and accepting; done  out  1  one-cycle completion pulse; status  out  2  completion code, valid with done.
REQ-007 SHALL have ports: opcode  in  8  instruction byte; data  in  8*MAX_DATA_SIZE  packed payload, byte i at [8i+7:8i]; data_len  in  LEN_W  payload count; wait_ack_mask  in  MAX_DATA_SIZE  bit i = wait ACK after byte i; send_synch  in  1  prefix 0x55.
REQ-008 SHALL have ports: waiting_for_ack  out  1  in ACK wait; ack_received  in  1  ACK pulse from RX path.
REQ-009 SHALL have ports: fifo_data  out  8  byte to TX FIFO; fifo_wr_en  out  1  write strobe; fifo_full  in  1  TX FIFO full.

Function
REQ-010 SHALL capture opcode, data, data_len, wait_ack_mask, send_synch into internal registers at the edge where start=1 and ready=1; inputs are don't-care afterwards.
REQ-011 SHALL ignore start while ready=0.
REQ-012 SHALL clamp captured data_len to MAX_DATA_SIZE when larger.
REQ-013 SHALL implement states IDLE, SYNCH, OPCODE, DATA, WAIT_ACK, DONE.
REQ-014 IDLE: ready=1; on start -> SYNCH if send_synch else OPCODE; ready=0 from next cycle.
REQ-015 SYNCH/OPCODE/DATA: write one byte per cycle only when fifo_full=0 that cycle; else hold state, fifo_wr_en=0.
REQ-016 fifo_data/fifo_wr_en SHALL be registered: byte written in cycle k appears with fifo_wr_en=1 in cycle k+1, for exactly one cycle per byte.
REQ-017 SYNCH writes 0x55 -> OPCODE; OPCODE writes opcode -> DATA (index 0) if len>0, else DONE.
REQ-018 DATA writes byte[idx]; if wait_ack_mask[idx]=1 -> WAIT_ACK; else if idx=len-1 -> DONE; else idx+1.
REQ-019 WAIT_ACK: waiting_for_ack=1; timer cleared on entry; ack_received=1 -> DONE if idx=len-1, else idx+1 and DATA.
REQ-020 ack_received SHALL be ignored outside WAIT_ACK.
REQ-021 WAIT_ACK without ack for ACK_TIMEOUT cycles -> DONE with status=01; ack in the final cycle wins (no timeout).
REQ-022 abort=1 in SYNCH/OPCODE/DATA/WAIT_ACK -> DONE with status=10, no further writes; abort wins over simultaneous ack; abort in IDLE/DONE ignored.
REQ-023 DONE: done=1 for one cycle, status 00 success / 01 timeout / 10 abort; next state IDLE; status holds until next done.
REQ-024 Back-to-back: start accepted in first IDLE cycle after DONE; minimum issue period = bytes + 2 cycles.

Reset
REQ-025 rst SHALL force IDLE; ready=0 during rst, 1 first cycle after; done=0, status=00, fifo_wr_en=0, fifo_data=0x00, waiting_for_ack=0, idx=0, timer=0.
REQ-026 rst mid-instruction SHALL drop it without done pulse or further FIFO writes.

Structure
REQ-027 State enum, status codes (UPDI_ST_OK/TIMEOUT/ABORT) and SYNCH constant 0x55 SHALL live in shared package updi_pkg.
REQ-028 ACK timer SHALL be sub-module updi_timeout_counter (params WIDTH, LIMIT; ports clk, rst, clear, enable, expired).

Verification
REQ-029 send_synch=1, opcode=0x44, len=2, data={0x11,0x22}, mask=0 -> writes 0x55,0x44,0x11,0x22 on consecutive cycles; done, status=00.
REQ-030 len=0, send_synch=0, opcode=0x80 -> single write 0x80; done 2 cycles after write cycle.
REQ-031 fifo_full high 3 cycles mid-payload -> no write while full; sequence intact, no duplicates.
REQ-032 len=3, mask=0b010, ack after 5 cycles -> waiting_for_ack after byte 1, byte 2 written after ack; status=00.
REQ-033 ACK_TIMEOUT=8, mask bit0, no ack -> 8 cycles waiting_for_ack, done with status=01; ack on cycle 8 -> status=00.
REQ-034 abort during byte 1 of 4 -> no byte 2/3 writes, status=10; rst mid-payload -> no done, ready after reset.
